// File: rtl/xdma_write_burst_ctrl.sv
// rtl/xdma_write_burst_ctrl.sv - per-burst address decode and beat steering for the XDMA write path
module xdma_write_burst_ctrl #(
  parameter int unsigned N_OUP     = 1,
  parameter type         data_t    = logic,
  parameter type         addr_t    = logic,
  parameter type         rule_t    = struct packed {
    logic [31:0] idx;
    addr_t       start_addr;
    addr_t       end_addr;
  },
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned LOG_N_OUP = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  rule_t [N_OUP-1:0]       addr_map_i,
  input  addr_t                   req_addr_i,
  input  logic [LEN_W-1:0]        req_len_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  data_t                   inp_data_i,
  input  logic                    inp_valid_i,
  output logic                    inp_ready_o,
  output data_t [N_OUP-1:0]       oup_data_o,
  output logic [N_OUP-1:0]        oup_last_o,
  output logic [N_OUP-1:0]        oup_valid_o,
  input  logic [N_OUP-1:0]        oup_ready_i,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output logic                    done_error_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [LOG_N_OUP-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   dec_valid;
  logic                   dec_ok;
  logic [31:0]            dec_idx;
  logic                   req_hs;
  logic                   beat_hs;
  logic                   last_beat;

  // Address decode: non-NAPOT, exclusive end, later rules take priority, no default port.
  // An index outside the port range is treated like a miss so the burst is sunk, not misrouted.
  always_comb begin
    dec_valid = 1'b0;
    dec_idx   = '0;
    for (int i = 0; i < int'(N_OUP); i++) begin
      if ((req_addr_i >= addr_map_i[i].start_addr) &&
          (req_addr_i <  addr_map_i[i].end_addr)) begin
        dec_valid = 1'b1;
        dec_idx   = addr_map_i[i].idx;
      end
    end
    dec_ok = dec_valid && (dec_idx < N_OUP);
  end

  // Handshake qualifiers; req_ready depends on state only, never on req_valid.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    req_hs      = req_valid_i && req_ready_o;
    beat_hs     = inp_valid_i && inp_ready_o;
    last_beat   = (cnt_q == '0);
  end

  // Combinational beat path: selected port mirrors the source, everything else is zero.
  always_comb begin
    oup_data_o  = '0;
    oup_last_o  = '0;
    oup_valid_o = '0;
    inp_ready_o = 1'b0;
    case (state_q)
      ST_BURST: begin
        oup_valid_o[sel_q] = inp_valid_i;
        oup_data_o[sel_q]  = inp_data_i;
        oup_last_o[sel_q]  = last_beat;
        inp_ready_o        = oup_ready_i[sel_q];
      end
      ST_DRAIN: begin
        inp_ready_o = 1'b1;
      end
      default: begin
        inp_ready_o = 1'b0;
      end
    endcase
  end

  // Completion and status flags decoded from the registered state.
  always_comb begin
    done_valid_o = (state_q == ST_RESP);
    done_error_o = (state_q == ST_RESP) && err_q;
    busy_o       = (state_q != ST_IDLE);
  end

  // Next-state: latch select and length once per burst, count beats down to zero.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          cnt_d = req_len_i;
          if (dec_ok) begin
            sel_d   = dec_idx[LOG_N_OUP-1:0];
            err_d   = 1'b0;
            state_d = ST_BURST;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_BURST, ST_DRAIN: begin
        if (beat_hs) begin
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      ST_RESP: begin
        if (done_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight without a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_xdma_write_burst_ctrl.sv
// tb/tb_xdma_write_burst_ctrl.sv - self-checking bench for xdma_write_burst_ctrl
module tb_xdma_write_burst_ctrl;

  localparam int N_OUP = 2;
  localparam int LEN_W = 8;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef struct packed {
    logic [31:0] idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;

  logic                clk = 1'b0;
  logic                rst_ni;
  rule_t [N_OUP-1:0]   addr_map_i;
  addr_t               req_addr_i;
  logic [LEN_W-1:0]    req_len_i;
  logic                req_valid_i;
  logic                req_ready_o;
  data_t               inp_data_i;
  logic                inp_valid_i;
  logic                inp_ready_o;
  data_t [N_OUP-1:0]   oup_data_o;
  logic [N_OUP-1:0]    oup_last_o;
  logic [N_OUP-1:0]    oup_valid_o;
  logic [N_OUP-1:0]    oup_ready_i;
  logic                done_valid_o;
  logic                done_ready_i;
  logic                done_error_o;
  logic                busy_o;

  int checks = 0;
  int failures = 0;
  bit src_pending = 1'b0;
  rule_t [N_OUP-1:0] map_normal;
  rule_t [N_OUP-1:0] map_swapped;

  always #5 clk = ~clk;

  xdma_write_burst_ctrl #(
    .N_OUP  (N_OUP),
    .data_t (data_t),
    .addr_t (addr_t),
    .rule_t (rule_t),
    .LEN_W  (LEN_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .addr_map_i   (addr_map_i),
    .req_addr_i   (req_addr_i),
    .req_len_i    (req_len_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .inp_data_i   (inp_data_i),
    .inp_valid_i  (inp_valid_i),
    .inp_ready_o  (inp_ready_o),
    .oup_data_o   (oup_data_o),
    .oup_last_o   (oup_last_o),
    .oup_valid_o  (oup_valid_o),
    .oup_ready_i  (oup_ready_i),
    .done_valid_o (done_valid_o),
    .done_ready_i (done_ready_i),
    .done_error_o (done_error_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: [0,0x1000) -> port 0, [0x1000,0x2000) -> port 1, else sink.
  function automatic int exp_port(input addr_t a);
    if (a < 32'h1000) return 0;
    if (a < 32'h2000) return 1;
    return -1;
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_inp_ready"}, inp_ready_o, 0);
    chk({tag, "_oup_valid"}, oup_valid_o, 0);
    chk({tag, "_oup_last"}, oup_last_o, 0);
    chk({tag, "_oup_data"}, oup_data_o, 0);
    chk({tag, "_done_valid"}, done_valid_o, 0);
    chk({tag, "_done_error"}, done_error_o, 0);
  endtask

  // One burst as a transaction: beats expected = len+1 on the decoded port (or sunk),
  // then exactly one completion. Entered and left at posedge+1.
  task automatic run_burst(input addr_t addr, input int len, input int vmode, input int rmode,
                           input int done_delay, input bit swap, input bit pend,
                           input addr_t paddr, input int plen);
    int port, total, sent, cyc, done_wait;
    bit err, finished, timed_out, exp_rdy;
    logic [1:0] ev, el;
    port = exp_port(addr);
    err = (port < 0);
    total = len + 1;
    req_valid_i = 1'b1;
    req_addr_i = addr;
    req_len_i = 8'(len);
    if (!src_pending) begin
      inp_data_i = $urandom;
      src_pending = 1'b1;
    end
    inp_valid_i = 1'b1;
    oup_ready_i = '1;
    done_ready_i = 1'b0;
    #1;
    chk("idle_req_ready", req_ready_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_inp_ready", inp_ready_o, 0);
    chk("idle_oup_valid", oup_valid_o, 0);
    chk("idle_done_valid", done_valid_o, 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (swap) addr_map_i = map_swapped;
    sent = 0; cyc = 0; done_wait = 0; finished = 1'b0; timed_out = 1'b0;
    while (!finished) begin
      if (cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
      if (!src_pending && (sent >= total || vmode == 0 || $urandom_range(2, 0) != 0)) begin
        src_pending = 1'b1;
        inp_data_i = $urandom;
      end
      inp_valid_i = src_pending;
      case (rmode)
        0: oup_ready_i = '1;
        1: oup_ready_i = 2'($urandom);
        default: oup_ready_i = (((cyc >> 1) & 1) == 0) ? 2'b11 : 2'b00;
      endcase
      done_ready_i = (sent >= total) && (done_wait >= done_delay);
      if (pend && sent >= total) begin
        req_valid_i = 1'b1;
        req_addr_i = paddr;
        req_len_i = 8'(plen);
      end
      #1;
      chk("burst_busy", busy_o, 1);
      chk("burst_req_ready", req_ready_o, 0);
      if (sent < total) begin
        chk("beat_done_valid", done_valid_o, 0);
        if (err) begin
          chk("drain_inp_ready", inp_ready_o, 1);
          chk("drain_oup_valid", oup_valid_o, 0);
          chk("drain_oup_last", oup_last_o, 0);
          chk("drain_oup_data", oup_data_o, 0);
          exp_rdy = 1'b1;
        end else begin
          ev = '0; ev[port] = inp_valid_i;
          el = '0; el[port] = (sent == total - 1);
          chk("burst_oup_valid", oup_valid_o, ev);
          chk("burst_oup_last", oup_last_o, el);
          chk("burst_oup_data", oup_data_o[port], inp_data_i);
          chk("burst_other_data", oup_data_o[1-port], 0);
          chk("burst_inp_ready", inp_ready_o, oup_ready_i[port]);
          exp_rdy = oup_ready_i[port];
        end
        if (inp_valid_i && exp_rdy) begin
          sent++;
          src_pending = 1'b0;
        end
      end else begin
        chk("resp_done_valid", done_valid_o, 1);
        chk("resp_done_error", done_error_o, err);
        chk("resp_inp_ready", inp_ready_o, 0);
        chk("resp_oup_valid", oup_valid_o, 0);
        if (done_ready_i) finished = 1'b1;
        else done_wait++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("burst_timeout", timed_out, 0);
    if (!pend) req_valid_i = 1'b0;
    done_ready_i = 1'b0;
    if (swap) addr_map_i = map_normal;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    map_normal[0] = '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000};
    map_normal[1] = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    map_swapped[0] = '{idx: 32'd1, start_addr: 32'h0000, end_addr: 32'h1000};
    map_swapped[1] = '{idx: 32'd0, start_addr: 32'h1000, end_addr: 32'h3000};
    addr_map_i = map_normal;
    rst_ni = 1'b0;
    req_addr_i = '0;
    req_len_i = '0;
    req_valid_i = 1'b0;
    inp_data_i = '0;
    inp_valid_i = 1'b0;
    oup_ready_i = '0;
    done_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Directed bursts
    run_burst(32'h1040, 3, 0, 0, 0, 1'b0, 1'b0, '0, 0);
    run_burst(32'h0000, 0, 0, 0, 0, 1'b0, 1'b0, '0, 0);
    run_burst(32'h3000, 2, 0, 0, 0, 1'b0, 1'b0, '0, 0);
    run_burst(32'h0800, 7, 0, 2, 0, 1'b0, 1'b0, '0, 0);
    run_burst(32'h1100, 2, 1, 1, 5, 1'b0, 1'b1, 32'h0010, 1);
    run_burst(32'h0010, 1, 1, 1, 0, 1'b0, 1'b0, '0, 0);

    // Reset after 2 of 4 beats
    req_valid_i = 1'b1;
    req_addr_i = 32'h1000;
    req_len_i = 8'd3;
    if (!src_pending) begin
      inp_data_i = $urandom;
      src_pending = 1'b1;
    end
    inp_valid_i = 1'b1;
    oup_ready_i = '1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("rst_pre_valid", oup_valid_o, 2'b10);
      @(posedge clk); #1;
      inp_data_i = $urandom;
    end
    rst_ni = 1'b0;
    #1;
    idle_outputs("midrst");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    inp_valid_i = 1'b0;
    src_pending = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done_valid", done_valid_o, 0);
    run_burst(32'h1ABC, 3, 0, 0, 0, 1'b0, 1'b0, '0, 0);

    // Boundary addresses and the full-length burst
    run_burst(32'h0FFF, 1, 1, 1, 1, 1'b1, 1'b0, '0, 0);
    run_burst(32'h2000, 0, 1, 1, 0, 1'b0, 1'b0, '0, 0);
    run_burst(32'h1FFF, 255, 0, 0, 0, 1'b1, 1'b0, '0, 0);

    // Randomized bursts with map changes mid-burst
    for (int k = 0; k < 25; k++) begin
      run_burst(addr_t'($urandom_range(32'h2FFF, 0)), int'($urandom_range(12, 0)), 1, 1,
                int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0, '0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
